// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_STEPS = 8;
  localparam int CNT_WIDTH = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a requester and the divider.
interface seq_divider_if;
  import seq_divider_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIV_WIDTH-1:0] quot;
  logic [DIV_WIDTH-1:0] rem;
  logic                 div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quot, rem, div_zero
  );

endinterface

// File: rtl/seq_divider_arith.sv
// Arithmetic cells for the divider: a one-bit full adder and the 2*a+b shift-in step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module two_a_plus_b
  import seq_divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic [DIV_WIDTH+1:0] y
);

  // Two extra bits so the sum never wraps for any 8-bit a and b.
  assign y = {1'b0, a, 1'b0} + {2'b00, b};

endmodule

// File: rtl/seq_divider.sv
// Unsigned 8-bit restoring divider, one quotient bit per cycle MSB first, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter logic [DIV_WIDTH-1:0] ZERO_QUOT = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  div_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] rem_reg;
  logic [DIV_WIDTH-1:0] quot_reg;
  logic [DIV_WIDTH-1:0] divisor_reg;
  logic [DIV_WIDTH-1:0] dividend_reg;
  logic                 div_zero_reg;

  logic                 in_ready;
  logic                 out_valid;
  logic                 accept;

  logic [DIV_WIDTH+1:0] shift_sum;
  logic [DIV_WIDTH-1:0] t;
  logic                 hi;
  logic [DIV_WIDTH-1:0] diff;
  logic [DIV_WIDTH:0]   carry;
  logic                 ge;

  // Shift the next dividend bit (quotient register MSB) into the partial remainder.
  two_a_plus_b u_shift (
    .a (rem_reg),
    .b ({{(DIV_WIDTH-1){1'b0}}, quot_reg[DIV_WIDTH-1]}),
    .y (shift_sum)
  );

  assign t  = shift_sum[DIV_WIDTH-1:0];
  assign hi = |shift_sum[DIV_WIDTH+1:DIV_WIDTH];

  // Trial subtract t - divisor as t + ~divisor + 1; the final carry means t >= divisor.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_sub
      full_adder u_fa (
        .a     (t[gi]),
        .b     (~divisor_reg[gi]),
        .c_in  (carry[gi]),
        .sum   (diff[gi]),
        .c_out (carry[gi+1])
      );
    end
  endgenerate

  assign ge = hi | carry[DIV_WIDTH];

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == DIV_IDLE);
    out_valid  = (state_reg == DIV_DONE);
    accept     = in_ready & bus.in_valid;
    case (state_reg)
      DIV_IDLE: begin
        if (accept) begin
          state_next = (bus.divisor == '0) ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (cnt_reg == '0) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.out_ready) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= DIV_IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        DIV_IDLE: begin
          if (accept) begin
            dividend_reg <= bus.dividend;
            divisor_reg  <= bus.divisor;
            if (bus.divisor == '0) begin
              quot_reg     <= ZERO_QUOT;
              rem_reg      <= bus.dividend;
              div_zero_reg <= 1'b1;
            end else begin
              quot_reg     <= bus.dividend;
              rem_reg      <= '0;
              cnt_reg      <= CNT_WIDTH'(DIV_STEPS - 1);
              div_zero_reg <= 1'b0;
            end
          end
        end
        DIV_RUN: begin
          // 8-bit wrap of t - divisor is exact: the true remainder is below divisor.
          rem_reg  <= ge ? diff : t;
          quot_reg <= {quot_reg[DIV_WIDTH-2:0], ge};
          cnt_reg  <= cnt_reg - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.quot      = quot_reg;
  assign bus.rem       = rem_reg;
  assign bus.div_zero  = div_zero_reg;

`ifndef SYNTHESIS
  a_identity: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !div_zero_reg) |->
      ((({8'b0, quot_reg} * {8'b0, divisor_reg}) + {8'b0, rem_reg}) == {8'b0, dividend_reg})
      && (rem_reg < divisor_reg));

  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    in_ready == (state_reg == DIV_IDLE));

  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !bus.out_ready) |=> out_valid);
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus a random sweep with output stalls.
module tb_seq_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } result_t;

  logic clk;
  logic rst;
  bit   stall_mode;
  bit   ready_level;
  int   checks;
  int   errors;
  int   n_sent;
  int   n_results;
  result_t exp_q[$];

  seq_divider_if bus();

  seq_divider #(.ZERO_QUOT(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; zero divisor returns all-ones and the dividend.
  function automatic result_t ref_div(input logic [7:0] a, input logic [7:0] b);
    result_t res;
    if (b == 8'd0) begin
      res.q  = 8'hFF;
      res.r  = a;
      res.dz = 1'b1;
    end else begin
      res.q  = a / b;
      res.r  = a % b;
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Consumer side: out_ready changes only just after a rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : ready_level;
    end
  end

  // Monitor: every result handshake pops one expectation.
  initial begin
    result_t got;
    result_t want;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = {bus.quot, bus.rem, bus.div_zero};
        n_results++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_extra: got q=%0d r=%0d dz=%0b, required no result",
                   got.q, got.r, got.dz);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL result: got q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0b",
                     got.q, got.r, got.dz, want.q, want.r, want.dz);
          end else begin
            $display("result %0d: q=%0d r=%0d dz=%0b", n_results, got.q, got.r, got.dz);
          end
        end
      end
    end
  end

  // Offer operands until accepted; junk is driven on the bus while not ready.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep);
    int  w;
    bit  seen;
    w    = 0;
    seen = 1'b0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    while (!seen && w < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        seen = 1'b1;
      end else begin
        w++;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        @(posedge clk);
        #1;
        bus.dividend = a;
        bus.divisor  = b;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready for %0d/%0d, required accept", a, b);
      bus.in_valid = 1'b0;
    end else begin
      if (keep) begin
        exp_q.push_back(ref_div(a, b));
        n_sent++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] corner_a [4];
    logic [7:0] corner_b [5];
    corner_a = '{8'd0, 8'd1, 8'd254, 8'd255};
    corner_b = '{8'd0, 8'd1, 8'd2, 8'd254, 8'd255};

    rst          = 1'b1;
    stall_mode   = 1'b0;
    ready_level  = 1'b1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_quot", int'(bus.quot), 0);
    check("reset_rem", int'(bus.rem), 0);
    check("reset_div_zero", int'(bus.div_zero), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 200/7: eight edges from accept to a valid result.
    send(8'd200, 8'd7, 1'b1);
    wait_valid(n);
    check("lat_200_7", n, 8);
    check("quot_200_7", int'(bus.quot), 28);
    check("rem_200_7", int'(bus.rem), 4);
    check("dz_200_7", int'(bus.div_zero), 0);
    drain("t1");

    send(8'd255, 8'd1, 1'b1);
    send(8'd255, 8'd255, 1'b1);
    send(8'd255, 8'd254, 1'b1);
    drain("t2");

    // Divide by zero: result is present right after the accept edge.
    send(8'h5A, 8'd0, 1'b1);
    wait_valid(n);
    check("lat_zero", n, 0);
    check("quot_zero", int'(bus.quot), 255);
    check("rem_zero", int'(bus.rem), 90);
    check("dz_zero", int'(bus.div_zero), 1);
    drain("t3");
    send(8'd10, 8'd3, 1'b1);
    drain("t3b");

    // Held result under back-pressure; a new request in the window must be ignored.
    ready_level = 1'b0;
    send(8'd100, 8'd3, 1'b1);
    wait_valid(n);
    check("lat_100_3", n, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_quot", int'(bus.quot), 33);
      check("hold_rem", int'(bus.rem), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      if (i == 5) begin
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        bus.in_valid = 1'b1;
      end
      if (i == 15) bus.in_valid = 1'b0;
    end
    ready_level = 1'b1;
    drain("t4");

    // Reset in the middle of a run drops the operation.
    send(8'd77, 8'd5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_quot", int'(bus.quot), 0);
    check("rst_rem", int'(bus.rem), 0);
    check("rst_div_zero", int'(bus.div_zero), 0);
    rst = 1'b0;
    send(8'd9, 8'd4, 1'b1);
    drain("t5");

    // Corner grid, then random pairs with random output stalls.
    stall_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 5; j++) begin
        send(corner_a[i], corner_b[j], 1'b1);
      end
    end
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 15))
        0:       b = 8'd0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        default: b = 8'($urandom);
      endcase
      send(a, b, 1'b1);
    end
    drain("t6");
    stall_mode = 1'b0;

    repeat (40) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("result_count", n_results, n_sent);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
